cp_mem_stage: RTL and testbench

CP_MEM_STAGE -- requirements
Module: cp_mem_stage

---
 rtl/cp_pkg.sv | 27 ++
 rtl/cp_mem_stage_if.sv | 23 ++
 rtl/cp_ld_align.sv | 32 +++
 rtl/cp_mem_stage.sv | 168 ++++++++++++++++
 tb/tb_cp_mem_stage.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp_pkg.sv
// Shared definitions for the memory stage: FSM states, func3 encodings and opcodes.
package cp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_OUT
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/cp_mem_stage_if.sv
// Data-memory request/response bus between the memory stage and the data memory.
interface cp_mem_stage_if;

    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/cp_ld_align.sv
// Load data alignment: picks the addressed byte/half of a read word and extends it.
module cp_ld_align
    import cp_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sext     = ~func3_i[2];

        case (func3_i[1:0])
            F3_LB[1:0]: result_o = {{24{byte_sel[7] & sext}}, byte_sel};
            F3_LH[1:0]: result_o = {{16{half_sel[15] & sext}}, half_sel};
            default:    result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/cp_mem_stage.sv
// Single-entry memory stage: address generation, dmem request/response and WB handoff.
module cp_mem_stage
    import cp_pkg::*;
#(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  valid_id_i,
    output logic                  ready_id_o,
    input  logic [31:0]           rs1_data_id_i,
    input  logic [31:0]           rs2_data_id_i,
    input  logic [4:0]            rd_addr_id_i,
    input  logic [2:0]            func3_id_i,
    input  logic [6:0]            opcode_id_i,
    input  logic [11:0]           imm_i_id_i,
    input  logic [11:0]           imm_s_id_i,
    input  logic                  rd_we_id_i,
    input  logic                  dmem_we_id_i,
    input  logic                  ld_be_id_i,
    input  logic                  st_be_id_i,

    cp_mem_stage_if.master        dmem,

    output logic                  valid_wb_o,
    input  logic                  ready_wb_i,
    output logic [4:0]            rd_addr_wb_o,
    output logic [31:0]           rd_data_wb_o,
    output logic                  rd_we_wb_o,
    output logic                  misalign_wb_o
);

    state_e      state_q, state_d;

    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        is_ld_q;
    logic [4:0]  rd_addr_q;
    logic [31:0] rd_data_q;
    logic        rd_we_q;
    logic        mis_q;

    logic        is_ld, is_st, is_mem, mis;
    logic [31:0] ea;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        capture, ld_done, req_c;
    logic [31:0] align_res;

    // Either the decoded flags or the raw opcode identify a memory access.
    assign is_ld  = ld_be_id_i | (opcode_id_i == OPC_LOAD);
    assign is_st  = ~is_ld & (st_be_id_i | (opcode_id_i == OPC_STORE));
    assign is_mem = is_ld | is_st;
    assign ea     = rs1_data_id_i + sext12(is_st ? imm_s_id_i : imm_i_id_i);

    assign mis = MISALIGN_CHECK && is_mem &&
                 (((func3_id_i[1:0] == F3_LH[1:0]) && ea[0]) ||
                  ((func3_id_i[1:0] == F3_LW[1:0]) && (ea[1:0] != 2'b00)));

    always_comb begin
        be_c    = '0;
        wdata_c = '0;
        case (func3_id_i[1:0])
            F3_SB[1:0]: begin
                be_c    = 4'b0001 << ea[1:0];
                wdata_c = {4{rs2_data_id_i[7:0]}};
            end
            F3_SH[1:0]: begin
                be_c    = ea[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{rs2_data_id_i[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = rs2_data_id_i;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ready_id_o = 1'b0;
        req_c      = 1'b0;
        valid_wb_o = 1'b0;
        capture    = 1'b0;
        ld_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_id_o = 1'b1;
                if (valid_id_i) begin
                    capture = 1'b1;
                    state_d = (is_mem && !mis) ? ST_REQ : ST_OUT;
                end
            end
            ST_REQ: begin
                req_c = 1'b1;
                if (dmem.gnt) state_d = is_ld_q ? ST_WAIT : ST_OUT;
            end
            ST_WAIT: begin
                if (dmem.rvalid) begin
                    ld_done = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                valid_wb_o = 1'b1;
                if (ready_wb_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            f3_q      <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            is_ld_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            rd_we_q   <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            if (capture) begin
                addr_q    <= ea;
                f3_q      <= func3_id_i;
                be_q      <= be_c;
                wdata_q   <= wdata_c;
                we_q      <= dmem_we_id_i;
                is_ld_q   <= is_ld;
                rd_addr_q <= rd_addr_id_i;
                rd_data_q <= is_mem ? '0 : ea;
                rd_we_q   <= rd_we_id_i && (rd_addr_id_i != 5'd0) && !is_st && !mis;
                mis_q     <= mis;
            end
            if (ld_done) rd_data_q <= align_res;
        end
    end

    cp_ld_align u_ld_align (
        .rdata_i   (dmem.rdata),
        .addr_lo_i (addr_q[1:0]),
        .func3_i   (f3_q),
        .result_o  (align_res)
    );

    assign dmem.req   = req_c;
    assign dmem.addr  = {addr_q[31:2], 2'b00};
    assign dmem.we    = we_q;
    assign dmem.be    = be_q;
    assign dmem.wdata = wdata_q;

    assign rd_addr_wb_o  = rd_addr_q;
    assign rd_data_wb_o  = rd_data_q;
    assign rd_we_wb_o    = rd_we_q;
    assign misalign_wb_o = mis_q;

endmodule

// File: tb/tb_cp_mem_stage.sv
// Directed vector bench for cp_mem_stage with hand-computed expectations.
module tb_cp_mem_stage;
    import cp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_id_i, ready_id_o;
    logic [31:0] rs1_data_id_i, rs2_data_id_i;
    logic [4:0]  rd_addr_id_i;
    logic [2:0]  func3_id_i;
    logic [6:0]  opcode_id_i;
    logic [11:0] imm_i_id_i, imm_s_id_i;
    logic        rd_we_id_i, dmem_we_id_i, ld_be_id_i, st_be_id_i;
    logic        valid_wb_o, ready_wb_i;
    logic [4:0]  rd_addr_wb_o;
    logic [31:0] rd_data_wb_o;
    logic        rd_we_wb_o, misalign_wb_o;

    int checks   = 0;
    int failures = 0;

    cp_mem_stage_if dmem ();

    cp_mem_stage #(.MISALIGN_CHECK(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_id_i    (valid_id_i),
        .ready_id_o    (ready_id_o),
        .rs1_data_id_i (rs1_data_id_i),
        .rs2_data_id_i (rs2_data_id_i),
        .rd_addr_id_i  (rd_addr_id_i),
        .func3_id_i    (func3_id_i),
        .opcode_id_i   (opcode_id_i),
        .imm_i_id_i    (imm_i_id_i),
        .imm_s_id_i    (imm_s_id_i),
        .rd_we_id_i    (rd_we_id_i),
        .dmem_we_id_i  (dmem_we_id_i),
        .ld_be_id_i    (ld_be_id_i),
        .st_be_id_i    (st_be_id_i),
        .dmem          (dmem),
        .valid_wb_o    (valid_wb_o),
        .ready_wb_i    (ready_wb_i),
        .rd_addr_wb_o  (rd_addr_wb_o),
        .rd_data_wb_o  (rd_data_wb_o),
        .rd_we_wb_o    (rd_we_wb_o),
        .misalign_wb_o (misalign_wb_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [11:0] imm_i;
        logic [11:0] imm_s;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        chk_data;
        logic [31:0] exp_rd;
        logic        exp_rd_we;
        logic        exp_mis;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_id_i    = 1'b0;
        rs1_data_id_i = '0;
        rs2_data_id_i = '0;
        rd_addr_id_i  = '0;
        func3_id_i    = '0;
        opcode_id_i   = 7'b0010011;
        imm_i_id_i    = '0;
        imm_s_id_i    = '0;
        rd_we_id_i    = 1'b0;
        dmem_we_id_i  = 1'b0;
        ld_be_id_i    = 1'b0;
        st_be_id_i    = 1'b0;
        ready_wb_i    = 1'b0;
        dmem.gnt      = 1'b0;
        dmem.rvalid   = 1'b0;
        dmem.rdata    = '0;
    endtask

    task automatic drive_id(input vec_t v);
        valid_id_i    = 1'b1;
        rs1_data_id_i = v.rs1;
        rs2_data_id_i = v.rs2;
        rd_addr_id_i  = v.rd;
        func3_id_i    = v.f3;
        opcode_id_i   = v.ld ? OPC_LOAD : (v.st ? OPC_STORE : 7'b0010011);
        imm_i_id_i    = v.imm_i;
        imm_s_id_i    = v.imm_s;
        rd_we_id_i    = v.rd_we;
        dmem_we_id_i  = v.we;
        ld_be_id_i    = v.ld;
        st_be_id_i    = v.st;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        bit   got_req, granted, rv_sent, done;
        int   lat;
        v = vecs[idx];
        got_req = 0; granted = 0; rv_sent = 0; done = 0; lat = -1;
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", idx), 32'(ready_id_o), 32'd1);
        drive_id(v);
        @(posedge clk);
        #1 valid_id_i = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            dmem.gnt    = 1'b0;
            dmem.rvalid = 1'b0;
            ready_wb_i  = 1'b0;
            if (c == 0) chk($sformatf("v%0d_ready_busy", idx), 32'(ready_id_o), 32'd0);
            if (granted && v.ld && !rv_sent) begin
                dmem.rvalid = 1'b1;
                dmem.rdata  = v.rdata;
                rv_sent     = 1;
            end else if (dmem.req && !got_req) begin
                got_req = 1;
                granted = 1;
                chk($sformatf("v%0d_addr", idx), dmem.addr, v.exp_addr);
                chk($sformatf("v%0d_be", idx), 32'(dmem.be), 32'(v.exp_be));
                chk($sformatf("v%0d_wdata", idx), dmem.wdata, v.exp_wdata);
                chk($sformatf("v%0d_we", idx), 32'(dmem.we), 32'(v.we));
                dmem.gnt = 1'b1;
            end else if (valid_wb_o) begin
                lat  = c;
                done = 1;
                if (v.chk_data) chk($sformatf("v%0d_rd_data", idx), rd_data_wb_o, v.exp_rd);
                chk($sformatf("v%0d_rd_addr", idx), 32'(rd_addr_wb_o), 32'(v.rd));
                chk($sformatf("v%0d_rd_we", idx), 32'(rd_we_wb_o), 32'(v.exp_rd_we));
                chk($sformatf("v%0d_misalign", idx), 32'(misalign_wb_o), 32'(v.exp_mis));
                ready_wb_i = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        ready_wb_i  = 1'b0;
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL v%0d_timeout: no valid_wb_o within 20 cycles", idx);
            pulse_reset();
        end else begin
            chk($sformatf("v%0d_req_seen", idx), 32'(got_req), 32'(v.exp_req));
            chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
            chk($sformatf("v%0d_valid_drop", idx), 32'(valid_wb_o), 32'd0);
            chk($sformatf("v%0d_ready_back", idx), 32'(ready_id_o), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          ld st we f3      rs1           rs2           imm_i    imm_s    rd     rdwe rdata         req addr          be       wdata         chk exp_rd        rdwe mis lat
        vecs[0]  = '{1, 0, 0, F3_LW,  32'h00001000, 32'h0,        12'h004, 12'h000, 5'd5,  1, 32'hDEADBEEF, 1, 32'h00001004, 4'b1111, 32'h0,        1, 32'hDEADBEEF, 1, 0, 2};
        vecs[1]  = '{1, 0, 0, F3_LB,  32'h00001003, 32'h0,        12'h000, 12'h000, 5'd3,  1, 32'h80FFFFFF, 1, 32'h00001000, 4'b1000, 32'h0,        1, 32'hFFFFFF80, 1, 0, 2};
        vecs[2]  = '{1, 0, 0, F3_LBU, 32'h00001003, 32'h0,        12'h000, 12'h000, 5'd3,  1, 32'h80FFFFFF, 1, 32'h00001000, 4'b1000, 32'h0,        1, 32'h00000080, 1, 0, 2};
        vecs[3]  = '{0, 1, 1, F3_SH,  32'h00002000, 32'h1234ABCD, 12'h000, 12'h002, 5'd7,  1, 32'h0,        1, 32'h00002000, 4'b1100, 32'hABCDABCD, 0, 32'h0,        0, 0, 1};
        vecs[4]  = '{1, 0, 0, F3_LW,  32'h00001000, 32'h0,        12'h002, 12'h000, 5'd5,  1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        0, 1, 0};
        vecs[5]  = '{0, 0, 0, 3'b000, 32'h00000010, 32'h0,        12'hFFF, 12'h000, 5'd1,  1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1, 32'h0000000F, 1, 0, 0};
        vecs[6]  = '{0, 0, 0, 3'b000, 32'hFFFFFFFF, 32'h0,        12'h002, 12'h000, 5'd0,  1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1, 32'h00000001, 0, 0, 0};
        vecs[7]  = '{1, 0, 0, F3_LH,  32'h00003000, 32'h0,        12'h002, 12'h000, 5'd9,  1, 32'h80011234, 1, 32'h00003000, 4'b1100, 32'h0,        1, 32'hFFFF8001, 1, 0, 2};
        vecs[8]  = '{1, 0, 0, F3_LHU, 32'h00003000, 32'h0,        12'h002, 12'h000, 5'd9,  1, 32'h80011234, 1, 32'h00003000, 4'b1100, 32'h0,        1, 32'h00008001, 1, 0, 2};
        vecs[9]  = '{0, 1, 1, F3_SB,  32'h00004000, 32'h000000A5, 12'h000, 12'hFFF, 5'd0,  0, 32'h0,        1, 32'h00003FFC, 4'b1000, 32'hA5A5A5A5, 0, 32'h0,        0, 0, 1};
        vecs[10] = '{0, 1, 1, F3_SW,  32'h00005000, 32'hCAFEF00D, 12'h000, 12'h008, 5'd2,  0, 32'h0,        1, 32'h00005008, 4'b1111, 32'hCAFEF00D, 0, 32'h0,        0, 0, 1};
        vecs[11] = '{1, 0, 0, F3_LH,  32'h00006001, 32'h0,        12'h000, 12'h000, 5'd4,  1, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        0, 1, 0};
        vecs[12] = '{0, 1, 1, F3_SW,  32'h00007002, 32'h55555555, 12'h000, 12'h000, 5'd4,  0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        0, 1, 0};
        vecs[13] = '{1, 0, 0, F3_LB,  32'h00001000, 32'h0,        12'h801, 12'h000, 5'd31, 1, 32'h12347F56, 1, 32'h00000800, 4'b0010, 32'h0,        1, 32'h0000007F, 1, 0, 2};
        vecs[14] = '{1, 0, 0, F3_LW,  32'h00000000, 32'h0,        12'h010, 12'h000, 5'd6,  0, 32'h01020304, 1, 32'h00000010, 4'b1111, 32'h0,        1, 32'h01020304, 0, 0, 2};

        rst_n = 1'b0;
        clear_inputs();
        #12;
        chk("rst_valid_wb", 32'(valid_wb_o), 32'd0);
        chk("rst_req", 32'(dmem.req), 32'd0);
        chk("rst_we", 32'(dmem.we), 32'd0);
        chk("rst_be", 32'(dmem.be), 32'd0);
        chk("rst_addr", dmem.addr, 32'd0);
        chk("rst_wdata", dmem.wdata, 32'd0);
        chk("rst_rd_data", rd_data_wb_o, 32'd0);
        chk("rst_rd_we", 32'(rd_we_wb_o), 32'd0);
        chk("rst_misalign", 32'(misalign_wb_o), 32'd0);
        chk("rst_ready_id", 32'(ready_id_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Stray grant/response while idle must not start anything
        @(negedge clk);
        dmem.gnt    = 1'b1;
        dmem.rvalid = 1'b1;
        @(negedge clk);
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        chk("stray_valid_wb", 32'(valid_wb_o), 32'd0);
        chk("stray_req", 32'(dmem.req), 32'd0);
        chk("stray_ready_id", 32'(ready_id_o), 32'd1);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Backpressure: grant withheld 3 cycles, then WB stalls 2 cycles
        @(negedge clk);
        drive_id(vecs[0]);
        @(posedge clk);
        #1 valid_id_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_req_%0d", c), 32'(dmem.req), 32'd1);
            chk($sformatf("bp_addr_%0d", c), dmem.addr, 32'h00001004);
            chk($sformatf("bp_be_%0d", c), 32'(dmem.be), 32'hF);
            chk($sformatf("bp_ready_id_%0d", c), 32'(ready_id_o), 32'd0);
        end
        @(negedge clk);
        chk("bp_req_at_gnt", 32'(dmem.req), 32'd1);
        dmem.gnt = 1'b1;
        @(negedge clk);
        dmem.gnt = 1'b0;
        chk("bp_wait_req", 32'(dmem.req), 32'd0);
        chk("bp_wait_valid", 32'(valid_wb_o), 32'd0);
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'h11223344;
        @(negedge clk);
        dmem.rvalid = 1'b0;
        dmem.rdata  = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_out_valid_%0d", c), 32'(valid_wb_o), 32'd1);
            chk($sformatf("bp_out_data_%0d", c), rd_data_wb_o, 32'h11223344);
            chk($sformatf("bp_out_rd_we_%0d", c), 32'(rd_we_wb_o), 32'd1);
            chk($sformatf("bp_out_ready_id_%0d", c), 32'(ready_id_o), 32'd0);
            if (c < 2) @(negedge clk);
        end
        ready_wb_i = 1'b1;
        @(posedge clk);
        #1 ready_wb_i = 1'b0;
        chk("bp_done_valid", 32'(valid_wb_o), 32'd0);
        chk("bp_done_ready_id", 32'(ready_id_o), 32'd1);

        // Reset during WAIT aborts the load; a late response is ignored
        @(negedge clk);
        drive_id(vecs[0]);
        @(posedge clk);
        #1 valid_id_i = 1'b0;
        @(negedge clk);
        chk("rw_req", 32'(dmem.req), 32'd1);
        dmem.gnt = 1'b1;
        @(negedge clk);
        dmem.gnt = 1'b0;
        chk("rw_in_wait_ready", 32'(ready_id_o), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_valid", 32'(valid_wb_o), 32'd0);
        chk("rw_rst_req", 32'(dmem.req), 32'd0);
        chk("rw_rst_be", 32'(dmem.be), 32'd0);
        chk("rw_rst_addr", dmem.addr, 32'd0);
        chk("rw_rst_ready", 32'(ready_id_o), 32'd1);
        @(negedge clk);
        rst_n       = 1'b1;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'hBADC0FFE;
        @(negedge clk);
        dmem.rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rw_after_valid_%0d", c), 32'(valid_wb_o), 32'd0);
            chk($sformatf("rw_after_ready_%0d", c), 32'(ready_id_o), 32'd1);
            chk($sformatf("rw_after_data_%0d", c), rd_data_wb_o, 32'd0);
            @(negedge clk);
        end

        // Stage is still usable after the aborted transaction
        run_vec(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
